// File: rtl/bus_uart_tx.sv
// bus_uart_tx: memory-mapped UART transmitter on a req/gnt/rvalid data bus.
// A byte FIFO feeds a baud generator and a frame FSM that drives tx_o.
// Define BUS_UART_TX_PARITY_EN to add a parity bit (8E1/8O1 frames); the
// default build sends 8N1 frames and CTRL bit1 reads as 0.
module bus_uart_tx #(
  parameter int ClkFreq   = 50000000,
  parameter int BaudRate  = 115200,
  parameter int FifoDepth = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int Divisor = ClkFreq / BaudRate;
  localparam int CntW    = (Divisor > 2) ? $clog2(Divisor) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Divisor - 1);
  localparam int AW      = $clog2(FifoDepth);
  localparam int PtrW    = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef BUS_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]      r_mem [FifoDepth];
  logic [PtrW-1:0] r_wrPtr, r_rdPtr;
  state_t          r_state;
  logic [CntW-1:0] r_baudCnt;
  logic [2:0]      r_bitIdx;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic            r_irqEn;
  logic            r_irq;
  logic            r_rvalid;
  logic [31:0]     r_rdata;
  logic            r_err;

  logic [PtrW-1:0] w_count;
  logic [31:0]     w_countWide;
  logic [3:0]      w_level;
  logic            w_full, w_empty, w_busy;
  logic [1:0]      w_sel;
  logic            w_txWrite, w_accept, w_push, w_pop, w_ctrlWrite;
  logic            w_tick;
  logic [7:0]      w_head;
  logic            w_irqEnNext;
  logic            w_parityOdd;
  logic [31:0]     w_rdata;
  logic            w_err;
  logic            w_unused;

  assign w_count     = r_wrPtr - r_rdPtr;
  assign w_countWide = 32'(w_count);
  assign w_level     = (w_countWide > 32'd15) ? 4'hF : w_countWide[3:0];
  assign w_full      = (w_count == PtrW'(FifoDepth));
  assign w_empty     = (w_count == '0);
  assign w_busy      = (r_state != S_IDLE);
  assign w_head      = r_mem[r_rdPtr[AW-1:0]];

  // A TXDATA push into a full FIFO is held off by withholding the grant.
  assign w_sel       = addr_i[3:2];
  assign w_txWrite   = req_i & we_i & (w_sel == 2'd0) & be_i[0];
  assign gnt_o       = req_i & ~(w_txWrite & w_full);
  assign w_accept    = req_i & gnt_o;
  assign w_push      = w_accept & w_txWrite;
  assign w_ctrlWrite = w_accept & we_i & (w_sel == 2'd2) & be_i[0];
  assign w_irqEnNext = w_ctrlWrite ? wdata_i[0] : r_irqEn;

  assign w_tick = (r_baudCnt == CntMax);
  assign w_pop  = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_tick));

`ifdef BUS_UART_TX_PARITY_EN
  logic r_parityOdd;
  logic r_parityBit;
  assign w_parityOdd = r_parityOdd;
`else
  assign w_parityOdd = 1'b0;
`endif

  assign w_unused = ^{addr_i[31:4], addr_i[1:0], be_i[3:1], wdata_i[31:8]};

  // Read-data and error decode for the addressed register.
  always_comb begin
    w_rdata = '0;
    w_err   = 1'b0;
    case (w_sel)
      2'd1:    w_rdata = {20'b0, w_level, 5'b0, w_busy, w_empty, w_full};
      2'd2:    w_rdata = {30'b0, w_parityOdd, r_irqEn};
      2'd3:    w_err   = 1'b1;
      default: w_rdata = '0;
    endcase
    if (we_i) w_rdata = '0;
  end

  // Registered bus response, one cycle after each accepted request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_accept;
      r_rdata  <= w_accept ? w_rdata : '0;
      r_err    <= w_accept & w_err;
    end
  end

  // Control register and the level interrupt (uses the new irq_en immediately).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_irqEn <= 1'b0;
      r_irq   <= 1'b0;
`ifdef BUS_UART_TX_PARITY_EN
      r_parityOdd <= 1'b0;
`endif
    end else begin
      r_irqEn <= w_irqEnNext;
      r_irq   <= w_irqEnNext & w_empty & ~w_busy;
`ifdef BUS_UART_TX_PARITY_EN
      if (w_ctrlWrite) r_parityOdd <= wdata_i[1];
`endif
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wrPtr[AW-1:0]] <= wdata_i[7:0];
  end

  // FIFO pointers, emptied on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Frame FSM with baud counter; tx_o is registered and idles high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_baudCnt <= '0;
      r_bitIdx  <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
`ifdef BUS_UART_TX_PARITY_EN
      r_parityBit <= 1'b0;
`endif
    end else begin
      if (r_state != S_IDLE) r_baudCnt <= w_tick ? '0 : r_baudCnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_state   <= S_START;
            r_baudCnt <= '0;
            r_shift   <= w_head;
            r_tx      <= 1'b0;
`ifdef BUS_UART_TX_PARITY_EN
            r_parityBit <= (^w_head) ^ r_parityOdd;
`endif
          end
        end
        S_START: begin
          if (w_tick) begin
            r_state  <= S_DATA;
            r_bitIdx <= '0;
            r_tx     <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_bitIdx == 3'd7) begin
`ifdef BUS_UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_parityBit;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_shift  <= r_shift >> 1;
              r_tx     <= r_shift[1];
              r_bitIdx <= r_bitIdx + 1'b1;
            end
          end
        end
`ifdef BUS_UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_tick) begin
            if (w_pop) begin
              r_state   <= S_START;
              r_baudCnt <= '0;
              r_shift   <= w_head;
              r_tx      <= 1'b0;
`ifdef BUS_UART_TX_PARITY_EN
              r_parityBit <= (^w_head) ^ r_parityOdd;
`endif
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;
  assign tx_o     = r_tx;
  assign irq_o    = r_irq;

endmodule
